// File: rtl/cache_bus_arbiter_pkg.sv
// Shared definitions for the cache bus arbiter: beat width, transfer types,
// read FSM encodings and read owner.
package cache_bus_arbiter_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned TYPE_W     = 3;
  localparam int unsigned LINE_OFF_W = 4;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_BYTE = 3'b000,
    TYPE_HALF = 3'b001,
    TYPE_WORD = 3'b010,
    TYPE_LINE = 3'b100
  } xfer_type_t;

  // One-hot, matching the cache's own state encoding style.
  typedef enum logic [1:0] {
    RD_IDLE = 2'b01,
    RD_BUSY = 2'b10
  } rd_state_t;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_DCACHE = 1'b1
  } owner_t;

endpackage

// File: rtl/cache_wr_buf.sv
// One-entry dirty-line write buffer: capture, drain, and a line-address
// compare used by the arbiter to hold back same-line dcache reads.
module cache_wr_buf
  import cache_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_req,
  input  logic [TYPE_W-1:0] cap_type,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [3:0]        cap_wstrb,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              drain_rdy,
  output logic              buf_valid,
  output logic [TYPE_W-1:0] buf_type,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [3:0]        buf_wstrb,
  output logic [DATA_W-1:0] buf_data,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic              cmp_hit
);

  logic capture;

  // Capture only when empty, drain only when full: the two never coincide.
  assign capture = cap_req && !buf_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
    end else if (capture) begin
      buf_valid <= 1'b1;
    end else if (buf_valid && drain_rdy) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      buf_type  <= cap_type;
      buf_addr  <= cap_addr;
      buf_wstrb <= cap_wstrb;
      buf_data  <= cap_data;
    end
  end

  assign cmp_hit = buf_valid &&
                   (cmp_addr[ADDR_W-1:LINE_OFF_W] == buf_addr[ADDR_W-1:LINE_OFF_W]);

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares the memory cache-line bus between icache and dcache: read arbiter,
// return routing and a one-entry write-back buffer. Optional CACHE_ARB_RR_EN
// selects round-robin arbitration instead of fixed dcache priority.
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_rd_req,
  input  logic [TYPE_W-1:0]       i_rd_type,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  output logic                    i_rd_rdy,
  output logic                    i_ret_valid,
  output logic                    i_ret_last,
  output logic [WIDTH-1:0]        i_ret_data,
  input  logic                    d_rd_req,
  input  logic [TYPE_W-1:0]       d_rd_type,
  input  logic [ADDR_W-1:0]       d_rd_addr,
  output logic                    d_rd_rdy,
  output logic                    d_ret_valid,
  output logic                    d_ret_last,
  output logic [WIDTH-1:0]        d_ret_data,
  input  logic                    d_wr_req,
  input  logic [TYPE_W-1:0]       d_wr_type,
  input  logic [ADDR_W-1:0]       d_wr_addr,
  input  logic [3:0]              d_wr_wstrb,
  input  logic [LINE_BYTES*8-1:0] d_wr_data,
  output logic                    d_wr_rdy,
  output logic                    rd_req,
  output logic [TYPE_W-1:0]       rd_type,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_rdy,
  input  logic                    ret_valid,
  input  logic                    ret_last,
  input  logic [WIDTH-1:0]        ret_data,
  output logic                    wr_req,
  output logic [TYPE_W-1:0]       wr_type,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [3:0]              wr_wstrb,
  output logic [LINE_BYTES*8-1:0] wr_data,
  input  logic                    wr_rdy
);

  localparam int unsigned DATA_W = LINE_BYTES * 8;

  rd_state_t state;
  owner_t    owner;
  logic      buf_valid;
  logic      d_hazard;
  logic      i_elig;
  logic      d_elig;
  logic      sel;
  logic      idle;
  logic      busy;
  logic      grant;

  cache_wr_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_buf (
    .clk       (clk),
    .reset     (reset),
    .cap_req   (d_wr_req),
    .cap_type  (d_wr_type),
    .cap_addr  (d_wr_addr),
    .cap_wstrb (d_wr_wstrb),
    .cap_data  (d_wr_data),
    .drain_rdy (wr_rdy),
    .buf_valid (buf_valid),
    .buf_type  (wr_type),
    .buf_addr  (wr_addr),
    .buf_wstrb (wr_wstrb),
    .buf_data  (wr_data),
    .cmp_addr  (d_rd_addr),
    .cmp_hit   (d_hazard)
  );

  assign d_wr_rdy = !buf_valid;
  assign wr_req   = buf_valid;

  assign idle   = (state == RD_IDLE);
  assign busy   = (state == RD_BUSY);
  assign i_elig = i_rd_req;
  assign d_elig = d_rd_req && !d_hazard;

  // sel: 1 picks the dcache, 0 the icache.
`ifdef CACHE_ARB_RR_EN
  logic rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (grant) begin
      rr_ptr <= !sel;
    end
  end

  assign sel = (i_elig && d_elig) ? rr_ptr : d_elig;
`else
  assign sel = d_elig;
`endif

  assign rd_req   = idle && (i_elig || d_elig);
  assign rd_type  = sel ? d_rd_type : i_rd_type;
  assign rd_addr  = sel ? d_rd_addr : i_rd_addr;
  assign grant    = rd_req && rd_rdy;
  assign i_rd_rdy = grant && !sel;
  assign d_rd_rdy = grant && sel;

  // Returns reach only the owner, and only while a read is outstanding.
  assign i_ret_valid = busy && (owner == OWN_ICACHE) && ret_valid;
  assign i_ret_last  = busy && (owner == OWN_ICACHE) && ret_last;
  assign i_ret_data  = ret_data;
  assign d_ret_valid = busy && (owner == OWN_DCACHE) && ret_valid;
  assign d_ret_last  = busy && (owner == OWN_DCACHE) && ret_last;
  assign d_ret_data  = ret_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RD_IDLE;
      owner <= OWN_ICACHE;
    end else begin
      unique case (state)
        RD_IDLE: begin
          if (grant) begin
            owner <= owner_t'(sel);
            state <= RD_BUSY;
          end
        end
        RD_BUSY: begin
          if (ret_valid && ret_last) begin
            state <= RD_IDLE;
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_cache_bus_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned DATA_W     = LINE_BYTES * 8;
`ifdef CACHE_ARB_RR_EN
  localparam bit RR       = 1'b1;
  localparam bit FIRST_D  = 1'b0;
`else
  localparam bit RR       = 1'b0;
  localparam bit FIRST_D  = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset;
  logic i_rd_req, d_rd_req, d_wr_req;
  logic [2:0] i_rd_type, d_rd_type, d_wr_type;
  logic [ADDR_W-1:0] i_rd_addr, d_rd_addr, d_wr_addr;
  logic [3:0] d_wr_wstrb;
  logic [DATA_W-1:0] d_wr_data;
  logic i_rd_rdy, i_ret_valid, i_ret_last;
  logic d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy;
  logic [31:0] i_ret_data, d_ret_data;
  logic rd_req, rd_rdy, ret_valid, ret_last, wr_req, wr_rdy;
  logic [2:0] rd_type, wr_type;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [31:0] ret_data;
  logic [3:0] wr_wstrb;
  logic [DATA_W-1:0] wr_data;

  cache_bus_arbiter #(.LINE_BYTES(LINE_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]        typ;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wstrb;
    logic [DATA_W-1:0] data;
  } wr_t;

  // Reference model: outstanding read (who owns it), fairness pointer and
  // the pending write-backs as a queue of at most one entry.
  wr_t wr_q[$];
  bit  m_known, m_busy, m_owner, m_ptr;
  int  n_total, n_pass;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Which requester should the bus serve right now (win: 1 = dcache)?
  task automatic predict(output bit req, output bit win);
    bit haz, ie, de;
    haz = (wr_q.size() != 0) && (d_rd_addr[ADDR_W-1:4] == wr_q[0].addr[ADDR_W-1:4]);
    ie  = i_rd_req;
    de  = d_rd_req && !haz;
    req = !m_busy && (ie || de);
    if (ie && de) win = RR ? m_ptr : 1'b1;
    else          win = de;
  endtask

  task automatic model_check();
    bit req, win;
    if (!m_known) return;
    predict(req, win);
    check("rd_req", 128'(rd_req), 128'(req));
    if (req) begin
      check("rd_addr", 128'(rd_addr), 128'(win ? d_rd_addr : i_rd_addr));
      check("rd_type", 128'(rd_type), 128'(win ? d_rd_type : i_rd_type));
    end
    check("i_rd_rdy", 128'(i_rd_rdy), 128'(req && !win && rd_rdy));
    check("d_rd_rdy", 128'(d_rd_rdy), 128'(req && win && rd_rdy));
    check("i_ret_valid", 128'(i_ret_valid), 128'(m_busy && !m_owner && ret_valid));
    check("i_ret_last", 128'(i_ret_last), 128'(m_busy && !m_owner && ret_last));
    check("d_ret_valid", 128'(d_ret_valid), 128'(m_busy && m_owner && ret_valid));
    check("d_ret_last", 128'(d_ret_last), 128'(m_busy && m_owner && ret_last));
    if (m_busy && ret_valid)
      check("ret_data", 128'(m_owner ? d_ret_data : i_ret_data), 128'(ret_data));
    check("d_wr_rdy", 128'(d_wr_rdy), 128'(wr_q.size() == 0));
    check("wr_req", 128'(wr_req), 128'(wr_q.size() != 0));
    if (wr_q.size() != 0) begin
      check("wr_type", 128'(wr_type), 128'(wr_q[0].typ));
      check("wr_addr", 128'(wr_addr), 128'(wr_q[0].addr));
      check("wr_wstrb", 128'(wr_wstrb), 128'(wr_q[0].wstrb));
      check("wr_data", 128'(wr_data), 128'(wr_q[0].data));
    end
  endtask

  task automatic model_update();
    bit req, win;
    wr_t e;
    predict(req, win);
    if (reset) begin
      m_known = 1'b1; m_busy = 1'b0; m_owner = 1'b0; m_ptr = 1'b0;
      wr_q.delete();
      return;
    end
    if (!m_known) return;
    if (!m_busy) begin
      if (req && rd_rdy) begin
        m_busy = 1'b1; m_owner = win; m_ptr = !win;
      end
    end else if (ret_valid && ret_last) begin
      m_busy = 1'b0;
    end
    if (wr_q.size() == 0) begin
      if (d_wr_req) begin
        e.typ = d_wr_type; e.addr = d_wr_addr; e.wstrb = d_wr_wstrb; e.data = d_wr_data;
        wr_q.push_back(e);
      end
    end else if (wr_rdy) begin
      void'(wr_q.pop_front());
    end
  endtask

  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic quiet();
    i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
    d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
    d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = '0;
    rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0; wr_rdy = 0;
  endtask

  task automatic last_beat();
    ret_valid = 1; ret_last = 1; ret_data = $urandom;
    tick();
    ret_valid = 0; ret_last = 0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    return 32'h0000_1000 | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
  endfunction

  initial begin
    n_total = 0; n_pass = 0; m_known = 0;
    quiet();
    reset = 1; tick(); tick(); reset = 0;

    // Reset state
    #1;
    check("rst_rd_req", 128'(rd_req), 128'(0));
    check("rst_wr_req", 128'(wr_req), 128'(0));
    check("rst_d_wr_rdy", 128'(d_wr_rdy), 128'(1));
    check("rst_i_ret_valid", 128'(i_ret_valid), 128'(0));
    tick();

    // Icache-only line read
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0040; rd_rdy = 1;
    #1;
    check("ic_rd_addr", 128'(rd_addr), 128'(32'h1C00_0040));
    check("ic_rd_rdy", 128'(i_rd_rdy), 128'(1));
    tick();
    quiet();
    for (int k = 0; k < 4; k++) begin
      ret_valid = 1; ret_last = (k == 3); ret_data = 32'(32'hA0 + k);
      #1;
      check("ic_beat_valid", 128'(i_ret_valid), 128'(1));
      check("ic_beat_data", 128'(i_ret_data), 128'(32'hA0 + k));
      check("ic_d_quiet", 128'(d_ret_valid), 128'(0));
      tick();
    end
    quiet();
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0080;
    #1;
    check("ic_idle_again", 128'(rd_req), 128'(1));
    tick();

    // Simultaneous reads from a fresh reset (pointer at icache)
    quiet(); reset = 1; tick(); reset = 0;
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0100;
    d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h0000_5000; rd_rdy = 1;
    #1;
    check("sim_first_d", 128'(d_rd_rdy), 128'(FIRST_D));
    check("sim_first_i", 128'(i_rd_rdy), 128'(!FIRST_D));
    tick();
    if (FIRST_D) d_rd_req = 0; else i_rd_req = 0;
    last_beat();
    #1;
    check("sim_second_i", 128'(i_rd_rdy), 128'(FIRST_D));
    check("sim_second_d", 128'(d_rd_rdy), 128'(!FIRST_D));
    tick();
    quiet(); last_beat();

    // Write-back then same-line read: read held until the buffer drains
    d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h0000_1230;
    d_wr_wstrb = 4'hF; d_wr_data = {16{8'h44}};
    #1; check("wb_accept", 128'(d_wr_rdy), 128'(1));
    tick();
    quiet();
    d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h0000_1234; rd_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("haz_blocked", 128'(rd_req), 128'(0));
      check("haz_wr_req", 128'(wr_req), 128'(1));
      tick();
    end
    wr_rdy = 1;
    #1;
    check("haz_hs_cycle", 128'(rd_req), 128'(0));
    check("haz_wr_data", 128'(wr_data), {16{8'h44}});
    tick();
    wr_rdy = 0;
    #1;
    check("haz_cleared", 128'(d_rd_rdy), 128'(1));
    check("wb_rdy_back", 128'(d_wr_rdy), 128'(1));
    tick();
    quiet(); last_beat();

    // Write-back and other-line read overlap
    d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h0000_2000;
    d_wr_wstrb = 4'hF; d_wr_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    quiet();
    d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h0000_3000; rd_rdy = 1;
    #1;
    check("ol_granted", 128'(d_rd_rdy), 128'(1));
    check("ol_wr_pending", 128'(wr_req), 128'(1));
    tick();
    quiet(); wr_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      ret_valid = 1; ret_last = (k == 3); ret_data = $urandom;
      tick();
    end
    quiet();

    // Uncached word read completes on one beat
    d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h0000_1004; rd_rdy = 1;
    tick();
    d_rd_req = 0; ret_valid = 1; ret_last = 1; ret_data = 32'hDEAD_BEEF;
    #1;
    check("uc_data", 128'(d_ret_data), 128'(32'hDEAD_BEEF));
    check("uc_last", 128'(d_ret_last), 128'(1));
    tick();
    quiet();
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0300; rd_rdy = 1;
    #1; check("uc_next_issue", 128'(i_rd_rdy), 128'(1));
    tick();
    quiet(); last_beat();

    // Byte write forwarded unchanged
    d_wr_req = 1; d_wr_type = 3'b000; d_wr_addr = 32'h0000_1002;
    d_wr_wstrb = 4'b0100; d_wr_data = 128'h00AB_0000;
    tick();
    quiet();
    #1;
    check("bw_type", 128'(wr_type), 128'(3'b000));
    check("bw_wstrb", 128'(wr_wstrb), 128'(4'b0100));
    check("bw_addr", 128'(wr_addr), 128'(32'h0000_1002));
    check("bw_data", 128'(wr_data), 128'h00AB_0000);
    wr_rdy = 1; tick(); quiet();

    // Reset while a line read is two beats in and a write is buffered
    d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h0000_4000;
    d_wr_wstrb = 4'hF; d_wr_data = {4{32'h5A5A_0001}};
    tick(); quiet();
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0200; rd_rdy = 1;
    tick(); quiet();
    for (int k = 0; k < 2; k++) begin
      ret_valid = 1; ret_data = $urandom; tick();
    end
    quiet(); reset = 1; tick(); reset = 0;
    ret_valid = 1; ret_data = 32'h1234_5678;
    #1;
    check("mrst_i_ret_valid", 128'(i_ret_valid), 128'(0));
    check("mrst_d_ret_valid", 128'(d_ret_valid), 128'(0));
    check("mrst_rd_req", 128'(rd_req), 128'(0));
    check("mrst_wr_req", 128'(wr_req), 128'(0));
    check("mrst_d_wr_rdy", 128'(d_wr_rdy), 128'(1));
    check("mrst_i_rd_rdy", 128'(i_rd_rdy), 128'(0));
    tick();
    quiet();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      i_rd_req   = ($urandom_range(0, 2) == 0);
      i_rd_type  = ($urandom_range(0, 1) != 0) ? 3'b100 : 3'($urandom_range(0, 2));
      i_rd_addr  = rand_addr();
      d_rd_req   = ($urandom_range(0, 1) != 0);
      d_rd_type  = ($urandom_range(0, 1) != 0) ? 3'b100 : 3'($urandom_range(0, 2));
      d_rd_addr  = rand_addr();
      d_wr_req   = ($urandom_range(0, 3) == 0);
      d_wr_type  = ($urandom_range(0, 1) != 0) ? 3'b100 : 3'($urandom_range(0, 2));
      d_wr_addr  = rand_addr();
      d_wr_wstrb = 4'($urandom_range(0, 15));
      d_wr_data  = {$urandom, $urandom, $urandom, $urandom};
      rd_rdy     = ($urandom_range(0, 1) != 0);
      wr_rdy     = ($urandom_range(0, 2) == 0);
      ret_valid  = ($urandom_range(0, 1) != 0);
      ret_last   = ret_valid && ($urandom_range(0, 3) == 0);
      ret_data   = $urandom;
      tick();
    end
    reset = 0;
    quiet();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
